// File: rtl/spart_bus_if.sv
// ---------------------------------------------------------------------------
// spart_bus_if -- processor-side register bus of the SPART controller.
//
// Signals
//   iocs    chip select; qualifies every access
//   iorw    1 = read, 0 = write
//   ioaddr  register select: 00 data, 01 status, 10 divisor low, 11 divisor high
//   wdata   write data
//   rdata   read data, driven combinationally by the controller
//
// Modports
//   master  the processor / bus side (drives the access, samples rdata)
//   slave   the SPART controller (receives the access, drives rdata)
// ---------------------------------------------------------------------------
interface spart_bus_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    input  wdata,
    output rdata
  );
endinterface : spart_bus_if

// File: rtl/spart_ctrl.sv
// ---------------------------------------------------------------------------
// spart_ctrl -- register/control block of a simple serial port.
//
// Holds the baud divisor and generates the 16x oversample tick, buffers one
// received byte with data-available / overrun flags, and buffers one byte for
// the transmitter behind a small launch FSM.
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   rst       asynchronous, active-high reset
//   bus       register bus (spart_bus_if.slave): iocs, iorw, ioaddr, wdata, rdata
//   enable    16x baud tick, one clk wide
//   rx_byte   byte from the receiver
//   rx_valid  one-cycle strobe, rx_byte valid
//   tx_ready  transmitter idle and able to accept a byte
//   tx_start  one-cycle launch strobe to the transmitter
//   tx_data   byte to the transmitter (always equal to the tx hold register)
//   rda       receive data available
//   tbr       transmit buffer ready (empty)
//
// Register map
//   00  read: received byte (clears rda)      write: byte to transmit
//   01  read: {5'b0, overrun, tbr, rda}       (clears overrun)
//   10  divisor[7:0]   read/write
//   11  divisor[15:8]  read/write
// ---------------------------------------------------------------------------
module spart_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'd325  // 50 MHz clk, 9600 baud, 16x
) (
  input  logic             clk,
  input  logic             rst,
  spart_bus_if.slave       bus,
  output logic             enable,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  input  logic             tx_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             rda,
  output logic             tbr
);

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DIV_LO = 2'b10,
    ADDR_DIV_HI = 2'b11
  } addr_e;

  typedef enum logic [1:0] {
    TX_EMPTY = 2'b00,
    TX_FULL  = 2'b01,
    TX_HOLD  = 2'b10
  } tx_state_e;

  // -------------------------------------------------------------------------
  // Bus access decode: every cycle with iocs high is exactly one access.
  // -------------------------------------------------------------------------
  logic  wr_en;
  logic  rd_en;
  addr_e addr;

  assign wr_en = bus.iocs & ~bus.iorw;
  assign rd_en = bus.iocs &  bus.iorw;
  assign addr  = addr_e'(bus.ioaddr);

  logic data_wr;
  logic div_lo_wr;
  logic div_hi_wr;
  logic div_wr;
  logic data_rd;
  logic stat_rd;

  assign data_wr   = wr_en && (addr == ADDR_DATA);
  assign div_lo_wr = wr_en && (addr == ADDR_DIV_LO);
  assign div_hi_wr = wr_en && (addr == ADDR_DIV_HI);
  assign div_wr    = div_lo_wr | div_hi_wr;
  assign data_rd   = rd_en && (addr == ADDR_DATA);
  assign stat_rd   = rd_en && (addr == ADDR_STATUS);

  // -------------------------------------------------------------------------
  // Baud divisor and tick generator
  // -------------------------------------------------------------------------
  logic [15:0] divisor;
  logic [15:0] div_next;
  logic [15:0] baud_cnt;

  // Byte-wise update of the divisor; the untouched byte keeps its value.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    div_next = divisor;
    if (div_lo_wr) div_next[7:0]  = bus.wdata;
    if (div_hi_wr) div_next[15:8] = bus.wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      divisor <= DEFAULT_DIV;
    end else begin
      divisor <= div_next;
    end
  end

  // Down-counter: counts divisor..0, so the tick period is divisor + 1.
  // A divisor write restarts the count from the new value on the same edge.
  // With a zero divisor the reload value is zero, which holds the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= DEFAULT_DIV;
    end else if (div_wr) begin
      baud_cnt <= div_next;
    end else if (baud_cnt == 16'd0) begin
      baud_cnt <= divisor;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  // Tick is the terminal-count cycle; suppressed while the divisor is zero
  // and in the cycle a divisor write restarts the count.
  assign enable = (baud_cnt == 16'd0) && (divisor != 16'd0) && !div_wr;

  // -------------------------------------------------------------------------
  // Receive holding register and flags
  // -------------------------------------------------------------------------
  logic [7:0] rx_hold;
  logic       overrun;
  logic       rx_lost;

  // A new byte is only "lost" if the previous one is still unread; a data
  // read in the same cycle consumes the old byte, so that is not an overrun.
  assign rx_lost = rx_valid && rda && !data_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hold <= 8'h00;
      rda     <= 1'b0;
    end else if (rx_valid) begin
      rx_hold <= rx_byte;
      rda     <= 1'b1;
    end else if (data_rd) begin
      rda     <= 1'b0;
    end
  end

  // Setting wins over the status-read clear so an overrun that happens in
  // the same cycle as the status read is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (rx_lost) begin
      overrun <= 1'b1;
    end else if (stat_rd) begin
      overrun <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Transmit buffer FSM
  //   TX_EMPTY --data write--> TX_FULL --tx_ready--> TX_HOLD --> TX_EMPTY
  // TX_HOLD spends one cycle ignoring tx_ready so the transmitter has time
  // to drop it after the launch strobe; without it a slow tx_ready could
  // launch the same byte twice.
  // -------------------------------------------------------------------------
  tx_state_e  tx_state_q;
  tx_state_e  tx_state_d;
  logic [7:0] tx_hold_q;
  logic       tx_start_q;
  logic       load_hold;
  logic       launch;

  always_comb begin
    tx_state_d = tx_state_q;
    load_hold  = 1'b0;
    launch     = 1'b0;
    unique case (tx_state_q)
      TX_EMPTY: begin
        if (data_wr) begin
          load_hold  = 1'b1;
          tx_state_d = TX_FULL;
        end
      end
      TX_FULL: begin
        if (tx_ready) begin
          launch     = 1'b1;
          tx_state_d = TX_HOLD;
        end
      end
      TX_HOLD: begin
        tx_state_d = TX_EMPTY;
      end
      default: begin
        tx_state_d = TX_EMPTY;
      end
    endcase
  end

  // Data writes outside TX_EMPTY never reach the hold register, so a byte
  // already queued for the transmitter cannot be corrupted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_EMPTY;
      tx_hold_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_start_q <= launch;
      if (load_hold) begin
        tx_hold_q <= bus.wdata;
      end
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_hold_q;
  assign tbr      = (tx_state_q == TX_EMPTY);

  // -------------------------------------------------------------------------
  // Read data mux; idle bus reads as zero.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.rdata = 8'h00;
    if (rd_en) begin
      unique case (addr)
        ADDR_DATA:   bus.rdata = rx_hold;
        ADDR_STATUS: bus.rdata = {5'b00000, overrun, tbr, rda};
        ADDR_DIV_LO: bus.rdata = divisor[7:0];
        ADDR_DIV_HI: bus.rdata = divisor[15:8];
        default:     bus.rdata = 8'h00;
      endcase
    end
  end

endmodule : spart_ctrl

// File: tb/tb_spart_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spart_ctrl -- directed self-checking bench for spart_ctrl.
// Inputs change just after a falling edge; outputs are sampled there too,
// half a cycle away from the rising edge that updates the design.
// ---------------------------------------------------------------------------
module tb_spart_ctrl;

  localparam logic [15:0] DEF_DIV = 16'd325;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rda;
  logic       tbr;

  int n_checks = 0;
  int n_fail   = 0;

  spart_bus_if bus ();

  spart_ctrl #(.DEFAULT_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .enable   (enable),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .rda      (rda),
    .tbr      (tbr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b0;
    bus.ioaddr = 2'b00;
    bus.wdata  = 8'h00;
  endtask

  // All bus/rx tasks start and end just after a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b0;
    bus.ioaddr = a;
    bus.wdata  = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b1;
    bus.ioaddr = a;
    #1 d = bus.rdata;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    int         first;
    int         last;
    int         cnt;
    int         idx;
    logic [7:0] data_at_start;
    logic       tbr_at_start;
    logic       tbr_hist [0:11];

    idle_bus();
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    // ---- reset state (before any clock edge) ----
    #2;
    chk("rst_tbr",      tbr,       1'b1);
    chk("rst_rda",      rda,       1'b0);
    chk("rst_tx_start", tx_start,  1'b0);
    chk("rst_tx_data",  tx_data,   8'h00);
    chk("rst_enable",   enable,    1'b0);
    chk("rst_rdata",    bus.rdata, 8'h00);

    @(negedge clk);
    bus_read(2'b10, rd); chk("rst_div_lo", rd, 8'h45);
    bus_read(2'b11, rd); chk("rst_div_hi", rd, 8'h01);

    // ---- first tick after release ----
    // n counts rising edges starting with the first one after release; the
    // value sampled here is what rising edge n sees. Expect DEF_DIV + 1.
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= int'(DEF_DIV) + 20; i++) begin
      if (enable) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
    chk("first_enable_edge", n, int'(DEF_DIV) + 1);
    @(negedge clk);
    chk("enable_one_wide", enable, 1'b0);

    // ---- divisor 4: tick every 5 cycles ----
    bus_write(2'b10, 8'h04);
    bus_write(2'b11, 8'h00);
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (enable) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      @(negedge clk);
    end
    chk("div4_first_tick", first, 4);
    chk("div4_last_tick",  last,  19);
    chk("div4_tick_count", cnt,   4);

    // ---- divisor 0: no ticks ----
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (enable) cnt++;
      @(negedge clk);
    end
    chk("div0_tick_count", cnt, 0);
    bus_read(2'b10, rd); chk("div0_rd_lo", rd, 8'h00);

    // ---- tx buffer fills while transmitter is busy ----
    bus_write(2'b00, 8'h3C);
    chk("tx_full_tbr",      tbr,      1'b0);
    chk("tx_full_data",     tx_data,  8'h3C);
    chk("tx_full_no_start", tx_start, 1'b0);
    bus_write(2'b00, 8'h77);
    chk("tx_write_dropped", tx_data,  8'h3C);

    // ---- single receive (tbr is 0 while the tx byte waits) ----
    rx_pulse(8'hA5);
    chk("rx_rda_set", rda, 1'b1);
    bus_read(2'b01, rd); chk("rx_status", rd, 8'h01);
    bus_read(2'b00, rd); chk("rx_data",   rd, 8'hA5);
    chk("rx_rda_clear", rda, 1'b0);

    // ---- overrun ----
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    bus_read(2'b01, rd); chk("ovr_status",  rd, 8'h05);
    bus_read(2'b00, rd); chk("ovr_data",    rd, 8'h22);
    bus_read(2'b01, rd); chk("ovr_cleared", rd, 8'h00);

    // ---- data read coincident with a new byte ----
    rx_pulse(8'h11);
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    rx_byte    = 8'h5A;
    rx_valid   = 1'b1;
    #1 chk("coin_rd_old", bus.rdata, 8'h11);
    @(negedge clk);
    idle_bus();
    rx_valid = 1'b0;
    chk("coin_rda_kept", rda, 1'b1);
    bus_read(2'b01, rd); chk("coin_no_overrun", rd, 8'h01);
    bus_read(2'b00, rd); chk("coin_rd_new",     rd, 8'h5A);

    // ---- launch the queued byte ----
    tx_ready = 1'b1;
    cnt = 0; idx = -1; data_at_start = 8'h00; tbr_at_start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tbr_hist[i] = tbr;
      if (tx_start) begin
        cnt++;
        if (idx < 0) begin
          idx           = i;
          data_at_start = tx_data;
          tbr_at_start  = tbr;
        end
      end
    end
    chk("launch_count",    cnt,           1);
    chk("launch_latency",  idx,           0);
    chk("launch_data",     data_at_start, 8'h3C);
    chk("launch_tbr_low",  tbr_at_start,  1'b0);
    if (idx >= 0 && idx <= 9) chk("tbr_after_launch", tbr_hist[idx + 2], 1'b1);
    else                      chk("tbr_after_launch", 1'b0, 1'b1);
    chk("tx_data_stable",  tx_data,       8'h3C);

    // ---- asynchronous reset with a pending tx byte and unread rx byte ----
    tx_ready = 1'b0;
    bus_write(2'b00, 8'h99);
    rx_pulse(8'h33);
    chk("pre_rst_tbr", tbr, 1'b0);
    chk("pre_rst_rda", rda, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tbr",      tbr,      1'b1);
    chk("arst_rda",      rda,      1'b0);
    chk("arst_tx_start", tx_start, 1'b0);
    chk("arst_tx_data",  tx_data,  8'h00);
    chk("arst_enable",   enable,   1'b0);
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b11;
    #1 chk("arst_div_hi", bus.rdata, 8'h01);
    idle_bus();
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start) cnt++;
    end
    chk("no_launch_after_rst", cnt, 0);
    bus_read(2'b01, rd); chk("post_rst_status", rd, 8'h02);
    bus_read(2'b00, rd); chk("post_rst_data",   rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spart_ctrl
